// File: rtl/sem_channel.sv
// Semaphore mailbox FIFO between two cpus; first-word-fall-through, registered flags, optional sticky error flags (SEM_CHANNEL_ERR_EN).
// Latency: a pushed token is visible on rd_data the cycle after the write edge.
// Backpressure: writes refused while wr_full, pops ignored while ~rd_valid.
module sem_channel #(
    parameter int DATA_WIDTH  = 1,
    parameter int DEPTH       = 4,
    parameter int LEVEL_WIDTH = $clog2(DEPTH) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DATA_WIDTH-1:0]  wr_data,
    input  logic                   wr_valid,
    output logic                   wr_empty,
    output logic                   wr_full,
    output logic [DATA_WIDTH-1:0]  rd_data,
    output logic                   rd_valid,
    input  logic                   rd_ack,
    output logic [LEVEL_WIDTH-1:0] level,
    output logic                   err_ovf,
    output logic                   err_udf
);

    localparam int PTR_WIDTH = $clog2(DEPTH);
    localparam logic [LEVEL_WIDTH-1:0] FULL_LEVEL = LEVEL_WIDTH'(DEPTH);
    localparam logic [LEVEL_WIDTH-1:0] ZERO_LEVEL = '0;

    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic [PTR_WIDTH-1:0]   wr_ptr;
    logic [PTR_WIDTH-1:0]   rd_ptr;
    logic [LEVEL_WIDTH-1:0] level_nxt;
    logic                   push;
    logic                   pop;

    // Full is registered, so a pop on a full cycle cannot free a slot for a same-cycle write.
    assign push = wr_valid & ~wr_full;
    assign pop  = rd_ack & rd_valid;

    always_comb begin
        level_nxt = level;
        if (push && !pop) begin
            level_nxt = level + 1'b1;
        end else if (pop && !push) begin
            level_nxt = level - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            wr_full  <= 1'b0;
            wr_empty <= 1'b1;
            rd_valid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            level    <= level_nxt;
            wr_full  <= (level_nxt == FULL_LEVEL);
            wr_empty <= (level_nxt == ZERO_LEVEL);
            rd_valid <= (level_nxt != ZERO_LEVEL);
        end
    end

    // Storage is deliberately left out of reset; stale words are masked by rd_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = rd_valid ? mem[rd_ptr] : '0;

`ifdef SEM_CHANNEL_ERR_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_ovf <= 1'b0;
            err_udf <= 1'b0;
        end else begin
            if (wr_valid && wr_full) begin
                err_ovf <= 1'b1;
`ifndef SYNTHESIS
                $display("sem_channel warning: write while full at %0t", $time);
`endif
            end
            if (rd_ack && !rd_valid) begin
                err_udf <= 1'b1;
`ifndef SYNTHESIS
                $display("sem_channel warning: pop while empty at %0t", $time);
`endif
            end
        end
    end
`else
    assign err_ovf = 1'b0;
    assign err_udf = 1'b0;
`endif

endmodule

// File: tb/tb_sem_channel.sv
// Randomized + directed bench for sem_channel; token queue reference model and a negedge monitor.
module tb_sem_channel;

    localparam int DW    = 1;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;
`ifdef SEM_CHANNEL_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk      = 1'b0;
    logic          rst      = 1'b0;
    logic [DW-1:0] wr_data  = '0;
    logic          wr_valid = 1'b0;
    logic          rd_ack   = 1'b0;
    logic          wr_empty;
    logic          wr_full;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic [LW-1:0] level;
    logic          err_ovf;
    logic          err_udf;

    always #5 clk = ~clk;

    sem_channel #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .wr_data  (wr_data),
        .wr_valid (wr_valid),
        .wr_empty (wr_empty),
        .wr_full  (wr_full),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_ack   (rd_ack),
        .level    (level),
        .err_ovf  (err_ovf),
        .err_udf  (err_udf)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Reference: the channel is just an ordered list of at most DEPTH tokens.
    logic [DW-1:0] mq[$];
    bit            m_ovf = 1'b0;
    bit            m_udf = 1'b0;
    bit            m_push;
    bit            m_pop;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            m_ovf = 1'b0;
            m_udf = 1'b0;
        end else begin
            m_push = wr_valid && (mq.size() < DEPTH);
            m_pop  = rd_ack && (mq.size() > 0);
            if (wr_valid && mq.size() == DEPTH) m_ovf = 1'b1;
            if (rd_ack && mq.size() == 0)       m_udf = 1'b1;
            if (m_pop)  void'(mq.pop_front());
            if (m_push) mq.push_back(wr_data);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        check("level",    32'(level),    32'(mq.size()));
        check("wr_empty", 32'(wr_empty), 32'(mq.size() == 0));
        check("wr_full",  32'(wr_full),  32'(mq.size() == DEPTH));
        check("rd_valid", 32'(rd_valid), 32'(mq.size() != 0));
        check("rd_data",  32'(rd_data),  (mq.size() != 0) ? 32'(mq[0]) : 32'd0);
        check("err_ovf",  32'(err_ovf),  32'(ERR_EN & m_ovf));
        check("err_udf",  32'(err_udf),  32'(ERR_EN & m_udf));
    end

    task automatic drive(input logic wv, input logic [DW-1:0] wd, input logic ra);
        wr_valid = wv;
        wr_data  = wd;
        rd_ack   = ra;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int wbias;
        int rbias;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        drive(1'b0, 1'b0, 1'b0);
        check("reset_level", 32'(level), 32'd0);
        check("reset_empty", 32'(wr_empty), 32'd1);

        // Fill to full, then one refused write.
        drive(1'b1, 1'b1, 1'b0);
        check("first_wr_valid", 32'(rd_valid), 32'd1);
        check("first_wr_data",  32'(rd_data),  32'd1);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        check("full_flag", 32'(wr_full), 32'd1);
        drive(1'b1, 1'b0, 1'b0);
        check("refused_level", 32'(level), 32'd4);
        drive(1'b0, 1'b0, 1'b0);

        // Drain in order 1,0,1,1.
        check("drain0", 32'(rd_data), 32'd1);
        drive(1'b0, 1'b0, 1'b1);
        check("drain1", 32'(rd_data), 32'd0);
        drive(1'b0, 1'b0, 1'b1);
        check("drain2", 32'(rd_data), 32'd1);
        drive(1'b0, 1'b0, 1'b1);
        check("drain3", 32'(rd_data), 32'd1);
        drive(1'b0, 1'b0, 1'b1);
        check("drained_empty", 32'(wr_empty), 32'd1);
        drive(1'b0, 1'b0, 1'b0);

        // Pointer wrap.
        for (int i = 0; i < 3; i++) drive(1'b1, DW'($urandom), 1'b0);
        for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
        check("wrap_full", 32'(wr_full), 32'd1);
        check("wrap_head", 32'(rd_data), 32'd0);
        for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 1'b1);

        // Write and pop together on an empty channel.
        drive(1'b1, 1'b1, 1'b1);
        check("empty_wp_level", 32'(level),    32'd1);
        check("empty_wp_valid", 32'(rd_valid), 32'd1);
        check("empty_wp_data",  32'(rd_data),  32'd1);
        drive(1'b0, 1'b0, 1'b1);

        // Asynchronous reset between edges with two tokens held.
        drive(1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b0);
        #3;
        rst = 1'b0;
        #1;
        check("async_level", 32'(level),    32'd0);
        check("async_valid", 32'(rd_valid), 32'd0);
        check("async_empty", 32'(wr_empty), 32'd1);
        check("async_full",  32'(wr_full),  32'd0);
        check("async_data",  32'(rd_data),  32'd0);
        check("async_ovf",   32'(err_ovf),  32'd0);
        check("async_udf",   32'(err_udf),  32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0);
        check("post_rst_valid", 32'(rd_valid), 32'd1);
        check("post_rst_data",  32'(rd_data),  32'd0);
        check("post_rst_level", 32'(level),    32'd1);

        // Random traffic with shifting write/read bias.
        wbias = 50;
        rbias = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 200 == 0) begin
                wbias = $urandom_range(10, 90);
                rbias = $urandom_range(10, 90);
            end
            drive(32'($urandom_range(0, 99)) < 32'(wbias), DW'($urandom),
                  32'($urandom_range(0, 99)) < 32'(rbias));
        end
        drive(1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
